// File: rtl/parameterized_onehot_decoder_if.sv
// Purpose: bundles the sampled ring-counter signals and the decoder's status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the decoder accepts a sample every cycle.
interface parameterized_onehot_decoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int ERR_W = 8
);
  logic             enable;
  logic [WIDTH-1:0] onehot_in;
  logic             err_clr;
  logic [IDX_W-1:0] index;
  logic             index_valid;
  logic             illegal;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  // Source side: the ring counter plus whoever clears the error count.
  modport master (
    output enable, onehot_in, err_clr,
    input  index, index_valid, illegal, seq_err, locked, err_count
  );

  // Decoder side.
  modport slave (
    input  enable, onehot_in, err_clr,
    output index, index_valid, illegal, seq_err, locked, err_count
  );
endinterface

// File: rtl/parameterized_onehot_decoder.sv
// Purpose: decodes a one-hot ring count to a binary index, flags illegal codes and sequence slips, tracks lock.
// Latency: 2 edges from onehot_in to index/flags/locked/err_count.
// Backpressure: none; a new sample is taken every cycle.
module parameterized_onehot_decoder #(
  parameter int WIDTH      = 8,
  parameter int IDX_W      = $clog2(WIDTH),
  parameter int LOCK_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  parameterized_onehot_decoder_if.slave   bus
);

  localparam int         CNT_W    = $clog2(WIDTH + 1);
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  // Stage 1 registers
  logic [WIDTH-1:0] in_q;
  logic             en_q;
  logic             in_vld;   // low until the first post-reset sample reaches stage 1

  // Stage 2 / checker state
  state_t           state;
  logic [3:0]       match_cnt;
  logic [IDX_W-1:0] prev_idx;
  logic             prev_en;
  logic             has_ref;
  logic [IDX_W-1:0] index_r;
  logic             index_valid_r;
  logic             illegal_r;
  logic             seq_err_r;
  logic             locked_r;
  logic [ERR_W-1:0] err_count_r;

  // Combinational decode of the stage-1 sample
  logic [CNT_W-1:0] ones_cnt;
  logic [IDX_W-1:0] dec_idx;
  logic             legal;
  logic [IDX_W-1:0] exp_idx;
  logic             mismatch;
  logic [3:0]       cnt_next;
  logic             err_event;

  // Capture the counter output and its enable unconditionally every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      en_q   <= 1'b0;
      in_vld <= 1'b0;
    end else begin
      in_q   <= bus.onehot_in;
      en_q   <= bus.enable;
      in_vld <= 1'b1;
    end
  end

  // Popcount and set-bit position of the captured sample.
  always_comb begin
    ones_cnt = '0;
    dec_idx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_q[i]) begin
        ones_cnt = ones_cnt + CNT_W'(1);
        dec_idx  = IDX_W'(i);
      end
    end
  end

  assign legal = (ones_cnt == CNT_W'(1));

  // Expected position wraps explicitly so non-power-of-two widths work.
  assign exp_idx  = (prev_en && (prev_idx == LAST_IDX)) ? '0 : prev_idx + IDX_W'(prev_en);
  assign mismatch = legal && has_ref && (dec_idx != exp_idx);

  // Next good-sample run length: restart on any break, extend on a clean match.
  always_comb begin
    cnt_next = '0;
    if (!legal) begin
      cnt_next = '0;
    end else if (!has_ref || mismatch) begin
      cnt_next = 4'd1;
    end else if (match_cnt != 4'hF) begin
      cnt_next = match_cnt + 4'd1;
    end else begin
      cnt_next = match_cnt;
    end
  end

  assign err_event = in_vld && (!legal || mismatch);

  // Stage 2 outputs, sequence reference and lock state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SEARCH;
      match_cnt     <= '0;
      prev_idx      <= '0;
      prev_en       <= 1'b0;
      has_ref       <= 1'b0;
      index_r       <= '0;
      index_valid_r <= 1'b0;
      illegal_r     <= 1'b0;
      seq_err_r     <= 1'b0;
      locked_r      <= 1'b0;
    end else if (in_vld) begin
      index_valid_r <= legal;
      illegal_r     <= !legal;
      seq_err_r     <= mismatch;
      has_ref       <= legal;
      if (legal) begin
        index_r  <= dec_idx;
        prev_idx <= dec_idx;
        prev_en  <= en_q;
      end
      case (state)
        SEARCH: begin
          match_cnt <= cnt_next;
          if (cnt_next >= LOCK_TGT) begin
            state    <= LOCKED;
            locked_r <= 1'b1;
          end
        end
        LOCKED: begin
          if (!legal || mismatch) begin
            state     <= SEARCH;
            locked_r  <= 1'b0;
            match_cnt <= cnt_next;
          end
        end
        default: begin
          state    <= SEARCH;
          locked_r <= 1'b0;
        end
      endcase
    end else begin
      illegal_r <= 1'b0;
      seq_err_r <= 1'b0;
    end
  end

  // Saturating error counter; a clear wins over a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= '0;
    end else if (bus.err_clr) begin
      err_count_r <= '0;
    end else if (err_event && (err_count_r != '1)) begin
      err_count_r <= err_count_r + ERR_W'(1);
    end
  end

  assign bus.index       = index_r;
  assign bus.index_valid = index_valid_r;
  assign bus.illegal     = illegal_r;
  assign bus.seq_err     = seq_err_r;
  assign bus.locked      = locked_r;
  assign bus.err_count   = err_count_r;

endmodule

// File: tb/tb_parameterized_onehot_decoder.sv
// Purpose: scoreboard bench for the one-hot decoder (8-bit error count and a 2-bit saturating twin).
// Latency: expectations come due 2 edges after each sample is driven.
// Backpressure: none; one sample per cycle.
module tb_parameterized_onehot_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] onehot_in = 8'h01;
  logic       err_clr = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parameterized_onehot_decoder_if #(.WIDTH(8), .ERR_W(8)) bus ();
  parameterized_onehot_decoder_if #(.WIDTH(8), .ERR_W(2)) bus_sat ();

  assign bus.enable        = enable;
  assign bus.onehot_in     = onehot_in;
  assign bus.err_clr       = err_clr;
  assign bus_sat.enable    = enable;
  assign bus_sat.onehot_in = onehot_in;
  assign bus_sat.err_clr   = err_clr;

  parameterized_onehot_decoder #(.WIDTH(8), .LOCK_COUNT(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  parameterized_onehot_decoder #(.WIDTH(8), .LOCK_COUNT(2), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_sat)
  );

  typedef struct {
    logic [7:0] oh;
    logic       en;
    logic       clr;   // clear acting on the edge where this vector's result appears
    logic [2:0] idx;
    logic       vld;
    logic       ill;
    logic       seq;
    logic       lock;
    logic [7:0] err;
    logic [1:0] sat;
  } vec_t;

  typedef struct {
    int   due;
    int   id;
    vec_t v;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic [7:0] oh, input logic en, input logic clr,
                     input logic [2:0] idx, input logic vld, input logic ill,
                     input logic seq, input logic lock, input logic [7:0] err,
                     input logic [1:0] sat);
    vec_t v;
    v.oh = oh; v.en = en; v.clr = clr; v.idx = idx; v.vld = vld; v.ill = ill;
    v.seq = seq; v.lock = lock; v.err = err; v.sat = sat;
    vecs.push_back(v);
  endtask

  // Drive vector j at the current negedge and queue its expected response.
  task automatic drive_vec(input int j);
    exp_t e;
    onehot_in = vecs[j].oh;
    enable    = vecs[j].en;
    err_clr   = (j > 0) ? vecs[j-1].clr : 1'b0;
    e.due = cyc + 2;
    e.id  = j;
    e.v   = vecs[j];
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus.index == 3'd0 && bus.index_valid == 1'b0 && bus.illegal == 1'b0 &&
        bus.seq_err == 1'b0 && bus.locked == 1'b0 && bus.err_count == 8'd0 &&
        bus_sat.err_count == 2'd0)
      passes++;
    else
      $display("FAIL %s: got idx=%0d vld=%b ill=%b seq=%b lock=%b err=%0d sat=%0d, expected all zero",
               name, bus.index, bus.index_valid, bus.illegal, bus.seq_err, bus.locked,
               bus.err_count, bus_sat.err_count);
  endtask

  // Monitor: compare the DUT against the oldest expectation once it is due.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        checks++;
        $display("FAIL vec%0d: result not observed at cycle %0d (now %0d)", sb[0].id, sb[0].due, cyc);
        void'(sb.pop_front());
      end else if (sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus.index == e.v.idx && bus.index_valid == e.v.vld && bus.illegal == e.v.ill &&
            bus.seq_err == e.v.seq && bus.locked == e.v.lock && bus.err_count == e.v.err &&
            bus_sat.err_count == e.v.sat)
          passes++;
        else
          $display("FAIL vec%0d: got idx=%0d vld=%b ill=%b seq=%b lock=%b err=%0d sat=%0d, expected idx=%0d vld=%b ill=%b seq=%b lock=%b err=%0d sat=%0d",
                   e.id, bus.index, bus.index_valid, bus.illegal, bus.seq_err, bus.locked,
                   bus.err_count, bus_sat.err_count, e.v.idx, e.v.vld, e.v.ill, e.v.seq,
                   e.v.lock, e.v.err, e.v.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   oh    en clr idx vld ill seq lock err  sat
    // free run with wrap
    add(8'h01, 1, 0, 0, 1, 0, 0, 0, 8'd0, 2'd0);
    add(8'h02, 1, 0, 1, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h04, 1, 0, 2, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h08, 1, 0, 3, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h10, 1, 0, 4, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h20, 1, 0, 5, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h40, 1, 0, 6, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h80, 1, 0, 7, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h01, 1, 0, 0, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h02, 1, 0, 1, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h04, 1, 0, 2, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h08, 1, 0, 3, 1, 0, 0, 1, 8'd0, 2'd0);
    // hold at 8'h10, then resume
    add(8'h10, 0, 0, 4, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h10, 0, 0, 4, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h10, 0, 0, 4, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h10, 1, 0, 4, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h20, 1, 0, 5, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h40, 1, 0, 6, 1, 0, 0, 1, 8'd0, 2'd0);
    // zero-hot and multi-hot while locked, then relock
    add(8'h00, 1, 0, 6, 0, 1, 0, 0, 8'd1, 2'd1);
    add(8'h18, 1, 0, 6, 0, 1, 0, 0, 8'd2, 2'd2);
    add(8'h20, 1, 0, 5, 1, 0, 0, 0, 8'd2, 2'd2);
    add(8'h40, 1, 0, 6, 1, 0, 0, 1, 8'd2, 2'd2);
    add(8'h80, 1, 0, 7, 1, 0, 0, 1, 8'd2, 2'd2);
    add(8'h01, 1, 0, 0, 1, 0, 0, 1, 8'd2, 2'd2);
    add(8'h02, 1, 0, 1, 1, 0, 0, 1, 8'd2, 2'd2);
    // skip 8'h08
    add(8'h04, 1, 0, 2, 1, 0, 0, 1, 8'd2, 2'd2);
    add(8'h10, 1, 0, 4, 1, 0, 1, 0, 8'd3, 2'd3);
    add(8'h20, 1, 0, 5, 1, 0, 0, 1, 8'd3, 2'd3);
    add(8'h40, 1, 0, 6, 1, 0, 0, 1, 8'd3, 2'd3);
    // clear with no error, then saturation and clear-vs-error
    add(8'h80, 1, 1, 7, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h00, 1, 0, 7, 0, 1, 0, 0, 8'd1, 2'd1);
    add(8'h00, 1, 0, 7, 0, 1, 0, 0, 8'd2, 2'd2);
    add(8'h00, 1, 0, 7, 0, 1, 0, 0, 8'd3, 2'd3);
    add(8'h00, 1, 0, 7, 0, 1, 0, 0, 8'd4, 2'd3);
    add(8'h00, 1, 0, 7, 0, 1, 0, 0, 8'd5, 2'd3);
    add(8'h00, 1, 1, 7, 0, 1, 0, 0, 8'd0, 2'd0);
    add(8'h01, 1, 0, 0, 1, 0, 0, 0, 8'd0, 2'd0);
    add(8'h02, 1, 0, 1, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h04, 1, 0, 2, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h08, 1, 0, 3, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h10, 0, 0, 4, 1, 0, 0, 1, 8'd0, 2'd0);
    // after the mid-stream reset
    add(8'h01, 1, 0, 0, 1, 0, 0, 0, 8'd0, 2'd0);
    add(8'h02, 1, 0, 1, 1, 0, 0, 1, 8'd0, 2'd0);
    add(8'h04, 1, 0, 2, 1, 0, 0, 1, 8'd0, 2'd0);

    // reset state
    repeat (3) @(negedge clk);
    check_zero("reset_state");

    rst_n = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      if (j > 0) @(negedge clk);
      drive_vec(j);
    end
    // counter held at 8'h10 while the pipeline drains
    @(negedge clk);
    err_clr = 1'b0;
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations still pending", sb.size());
      sb.delete();
    end

    // asynchronous reset between edges while locked
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    onehot_in = 8'h01;
    enable    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 41; j <= 43; j++) begin
      if (j > 41) @(negedge clk);
      drive_vec(j);
    end
    @(negedge clk);
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL final_drain: %0d expectations still pending", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
